// File: rtl/lc3b_mem_responder_if.sv
// LC-3b CPU-to-memory bus. The CPU (master) holds mem_read or mem_write, with address,
// data and mask stable, until the one-cycle mem_resp pulse. It may present a new request in that cycle.
interface lc3b_mem_responder_if;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  mem_wmask;
  logic [15:0] mem_address;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        proto_err;

  modport master (
    output mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    input  mem_rdata, mem_resp, proto_err
  );

  modport slave (
    input  mem_read, mem_write, mem_wmask, mem_address, mem_wdata,
    output mem_rdata, mem_resp, proto_err
  );
endinterface

// File: rtl/lc3b_mem_responder.sv
// Word-organised RAM target for the LC-3b memory bus. It responds after a fixed latency
// and raises a sticky proto_err when the initiator breaks the request-hold rules.
module lc3b_mem_responder #(
  parameter int ADDR_WORDS_LOG2 = 10,
  parameter int LATENCY         = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  lc3b_mem_responder_if.slave  mem_if,
  output logic                 o_dbg_state
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;
  localparam int         DEPTH   = 1 << ADDR_WORDS_LOG2;
  localparam logic [3:0] LAT_M1  = 4'(LATENCY - 1);

  logic [15:0] r_mem [DEPTH];

  logic [0:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_is_read;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [1:0]  r_wmask;
  logic        r_resp;
  logic [15:0] r_rdata;
  logic        r_perr;

  logic                       w_req_one;
  logic                       w_req_both;
  logic                       w_viol;
  logic                       w_fire;
  logic [ADDR_WORDS_LOG2-1:0] w_idx;

  assign w_req_one  = mem_if.mem_read ^ mem_if.mem_write;
  assign w_req_both = mem_if.mem_read & mem_if.mem_write;
  assign w_idx      = mem_if.mem_address[ADDR_WORDS_LOG2:1];

  // While BUSY the live inputs must match the captured request. Data and mask only matter for writes.
  assign w_viol = (r_state == ST_BUSY) &&
                  (!w_req_one ||
                   (mem_if.mem_read != r_is_read) ||
                   (mem_if.mem_address != r_addr) ||
                   (!r_is_read && (mem_if.mem_wdata != r_wdata)) ||
                   (!r_is_read && (mem_if.mem_wmask != r_wmask)));

  // The memory operation happens on the edge that raises mem_resp. At that edge the live inputs
  // equal the request, so they drive the RAM directly.
  assign w_fire = ((r_state == ST_IDLE) && w_req_one && (LATENCY == 1)) ||
                  ((r_state == ST_BUSY) && !w_viol && (r_cnt == 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 4'd0;
      r_is_read <= 1'b0;
      r_addr    <= 16'h0000;
      r_wdata   <= 16'h0000;
      r_wmask   <= 2'b00;
      r_resp    <= 1'b0;
      r_rdata   <= 16'h0000;
      r_perr    <= 1'b0;
    end else begin
      r_resp <= w_fire;
      if (w_fire && mem_if.mem_read) r_rdata <= r_mem[w_idx];
      case (r_state)
        ST_IDLE: begin
          if (w_req_both) begin
            r_perr <= 1'b1;
          end else if (w_req_one) begin
            r_is_read <= mem_if.mem_read;
            r_addr    <= mem_if.mem_address;
            r_wdata   <= mem_if.mem_wdata;
            r_wmask   <= mem_if.mem_wmask;
            if (LATENCY > 1) begin
              r_state <= ST_BUSY;
              r_cnt   <= LAT_M1;
            end
          end
        end
        default: begin
          if (w_viol) begin
            r_perr  <= 1'b1;
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else if (r_cnt == 4'd1) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_fire && mem_if.mem_write) begin
      if (mem_if.mem_wmask[0]) r_mem[w_idx][7:0]  <= mem_if.mem_wdata[7:0];
      if (mem_if.mem_wmask[1]) r_mem[w_idx][15:8] <= mem_if.mem_wdata[15:8];
    end
  end

  assign mem_if.mem_rdata  = r_rdata;
  assign mem_if.mem_resp   = r_resp;
  assign mem_if.proto_err  = r_perr;
  assign o_dbg_state       = r_state;

endmodule

// File: doc/lc3b_mem_responder.md
Name: lc3b_mem_responder

Overview:
- Memory-side responder for the LC-3b CPU memory interface. The CPU is the initiator; this block is the target.
- Accepts one word read or byte-masked write at a time, waits a programmable latency, then pulses mem_resp.
- Backs the datapath in simulation and FPGA bring-up, and later sits behind the cache as the physical-memory stand-in.
- Holds a word-organised RAM and flags protocol violations by the initiator.

Parameters:
- ADDR_WORDS_LOG2, 10, log2 of RAM depth in 16-bit words. Default is 1024 words (2 KB).
- LATENCY, 4, cycles from request acceptance to mem_resp. Legal range 1..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_read  input  1  read request; held high by the CPU until mem_resp.
- mem_write  input  1  write request; held high by the CPU until mem_resp.
- mem_wmask  input  2  byte enables (lc3b_mem_wmask). Bit0 selects [7:0], bit1 selects [15:8].
- mem_address  input  16  byte address (lc3b_word). Bit0 is ignored for word indexing.
- mem_wdata  input  16  write data (lc3b_word).
- mem_rdata  output  16  read data (lc3b_word). Valid in the mem_resp cycle of a read.
- mem_resp  output  1  single-cycle completion pulse.
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high.
- Reset values: mem_resp=0, mem_rdata=16'h0000, proto_err=0, state=IDLE, latency counter=0. RAM contents are not cleared.
- FSM states: IDLE and BUSY.
- IDLE behaviour:
  - Exactly one of mem_read/mem_write high: capture op, word index = mem_address[ADDR_WORDS_LOG2:1], wmask and wdata. Load counter with LATENCY-1 and go to BUSY.
  - If LATENCY=1: go directly to the response cycle instead (mem_resp high on the next edge).
  - Both mem_read and mem_write high: set proto_err, accept nothing, stay IDLE.
- BUSY behaviour:
  - Decrement the counter each cycle. When it reaches 0, the next cycle is the response cycle:
    - mem_resp=1 for exactly one cycle.
    - Read: mem_rdata = RAM[index].
    - Write: RAM[index][7:0] <= wdata[7:0] if wmask[0]; RAM[index][15:8] <= wdata[15:8] if wmask[1].
  - After the response cycle, return to IDLE.
- Latency: with the request first high in cycle t, mem_resp is high in cycle t+LATENCY.
- Write visibility: write data is visible to a read accepted in the cycle after the write's mem_resp.
- Back-to-back requests: a request high in the cycle after mem_resp is a new request, accepted normally. The CPU drops the old request on the mem_resp edge. No dead cycle is added.
- mem_rdata holding:
  - mem_rdata holds its last read value through writes and idle cycles.
  - It updates only in read response cycles.
- wmask=00 write: RAM is unchanged; mem_resp is still issued.
- mem_wmask is ignored for reads.
- Address wrap: address bits above ADDR_WORDS_LOG2 are ignored, so addresses alias modulo the RAM size.
- Initiator violations while BUSY:
  - Violations: request dropped, op changed, or mem_address/mem_wdata/mem_wmask changed before mem_resp.
  - Response: set proto_err, abort to IDLE, perform no write, issue no mem_resp.
  - Inputs are re-evaluated in IDLE on the next cycle.
- Reset mid-operation: abort, no RAM write, mem_resp=0, state IDLE. proto_err clears.
- proto_err stays high until reset.

Test Plan:
- Write then read, LATENCY=4: write addr 16'h0010, wdata 16'hBEEF, wmask 11 at cycle 0. mem_resp at cycle 4 only. Read 16'h0010 at cycle 5; mem_resp at 9 with mem_rdata=16'hBEEF.
- Byte masks: preload 16'h1234 at 16'h0020. Write 16'hABCD with wmask 01, then read: 16'h12CD. Write 16'hABCD with wmask 10, then read: 16'hABCD. Write with wmask 00: data unchanged and mem_resp still pulses.
- Odd and aliased address, ADDR_WORDS_LOG2=10: write 16'h5A5A at 16'h0031. Read 16'h0030 returns 16'h5A5A. Read 16'h0830 (aliases) returns 16'h5A5A.
- LATENCY=1 back-to-back: reads at 16'h0000 and 16'h0002 issued in consecutive cycles. mem_resp high in 2 consecutive cycles with the correct data each time.
- Violation: mem_read and mem_write both high gives proto_err=1 and no mem_resp. Write that drops mem_write at cycle 2 of 4 gives proto_err=1, no mem_resp, and a later read shows old data.
- Reset mid-write: assert reset at cycle 2 of a 16'h0040 write. mem_resp never pulses; a subsequent read returns the prior contents; proto_err=0.
